// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared mode codes, FSM states and default latencies for the calculator sequencer
package calc_pkg;

    localparam logic [3:0] MODE_EDIT = 4'd1;
    localparam logic [3:0] MODE_ADD  = 4'd2;
    localparam logic [3:0] MODE_SUB  = 4'd3;
    localparam logic [3:0] MODE_MUL  = 4'd4;
    localparam logic [3:0] MODE_DIV  = 4'd5;
    localparam logic [3:0] MODE_TEST = 4'd7;
    localparam logic [3:0] MODE_ERR  = 4'd8;

    localparam int DEF_LAT_ADDSUB  = 3;
    localparam int DEF_LAT_MUL     = 6;
    localparam int DEF_DIV_TIMEOUT = 64;
    localparam int DEF_CNT_W       = 7;

    typedef enum logic [2:0] {
        S_EDIT,
        S_OPND,
        S_EXEC,
        S_DONE,
        S_ERR,
        S_TEST
    } fsm_t;

endpackage

// File: rtl/lat_timer.sv
// rtl/lat_timer.sv - clear/enable saturating counter with terminal compare
module lat_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == term_i);

endmodule

// File: rtl/calc_seq_ctrl.sv
// rtl/calc_seq_ctrl.sv - key-driven mode sequencer for the BCD calculator datapath
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int LAT_ADDSUB  = DEF_LAT_ADDSUB,
    parameter int LAT_MUL     = DEF_LAT_MUL,
    parameter int DIV_TIMEOUT = DEF_DIV_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_add,
    input  logic             key_sub,
    input  logic             key_mul,
    input  logic             key_div,
    input  logic             key_eq,
    input  logic             key_clr,
    input  logic             key_test,
    input  logic             divisor_zero,
    input  logic             div_done,
    input  logic             res_ovf,
    output logic [3:0]       state,
    output logic             busy,
    output logic             commit,
    output logic             error,
    output logic [CNT_W-1:0] cnt_dbg
);

    fsm_t             fsm_q, fsm_d;
    logic [3:0]       op_q, op_d;
    logic [3:0]       state_q, state_d;
    logic             busy_q, commit_q, error_q;
    logic             op_key;
    logic [3:0]       op_sel;
    logic             is_div;
    logic             tmr_clr, tmr_term;
    logic [CNT_W-1:0] tmr_limit;

    assign op_key = key_add | key_sub | key_mul | key_div;
    assign is_div = (op_q == MODE_DIV);

    always_comb begin
        op_sel = MODE_DIV;
        if (key_add) begin
            op_sel = MODE_ADD;
        end else if (key_sub) begin
            op_sel = MODE_SUB;
        end else if (key_mul) begin
            op_sel = MODE_MUL;
        end
    end

    // One timer serves both the fixed latency and the divider watchdog.
    always_comb begin
        tmr_limit = CNT_W'(LAT_ADDSUB - 1);
        if (is_div) begin
            tmr_limit = CNT_W'(DIV_TIMEOUT - 1);
        end else if (op_q == MODE_MUL) begin
            tmr_limit = CNT_W'(LAT_MUL - 1);
        end
    end

    lat_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tmr_clr),
        .en_i   (fsm_q == S_EXEC),
        .term_i (tmr_limit),
        .cnt_o  (cnt_dbg),
        .term_o (tmr_term)
    );

    always_comb begin
        fsm_d   = fsm_q;
        op_d    = op_q;
        tmr_clr = 1'b0;
        case (fsm_q)
            S_EDIT: begin
                if (!key_clr) begin
                    if (key_test) begin
                        fsm_d = S_TEST;
                    end else if (!key_eq && op_key) begin
                        fsm_d = S_OPND;
                        op_d  = op_sel;
                    end
                end
            end
            S_OPND: begin
                if (key_clr) begin
                    fsm_d = S_EDIT;
                end else if (!key_test) begin
                    if (key_eq) begin
                        if (is_div && divisor_zero) begin
                            fsm_d = S_ERR;
                        end else begin
                            fsm_d   = S_EXEC;
                            tmr_clr = 1'b1;
                        end
                    end else if (op_key) begin
                        op_d = op_sel;
                    end
                end
            end
            S_EXEC: begin
                if (key_clr) begin
                    fsm_d = S_EDIT;
                end else if (is_div ? div_done : tmr_term) begin
                    fsm_d = res_ovf ? S_ERR : S_DONE;
                end else if (is_div && tmr_term) begin
                    fsm_d = S_ERR;
                end
            end
            S_DONE: fsm_d = S_EDIT;
            S_ERR: begin
                if (key_clr) begin
                    fsm_d = S_EDIT;
                end
            end
            S_TEST: begin
                if (key_clr || key_test) begin
                    fsm_d = S_EDIT;
                end
            end
            default: fsm_d = S_EDIT;
        endcase
    end

    // Outputs are decoded from the next state so they move on the transition edge.
    always_comb begin
        case (fsm_d)
            S_OPND, S_EXEC: state_d = op_d;
            S_ERR:          state_d = MODE_ERR;
            S_TEST:         state_d = MODE_TEST;
            default:        state_d = MODE_EDIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= S_EDIT;
            op_q     <= MODE_ADD;
            state_q  <= MODE_EDIT;
            busy_q   <= 1'b0;
            commit_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            op_q     <= op_d;
            state_q  <= state_d;
            busy_q   <= (fsm_d == S_EXEC);
            commit_q <= (fsm_d == S_DONE);
            error_q  <= (fsm_d == S_ERR);
        end
    end

    assign state  = state_q;
    assign busy   = busy_q;
    assign commit = commit_q;
    assign error  = error_q;

endmodule
